// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the cache-line controller.
//   state_e      controller state encoding (IDLE=0, HIT=1, WRITEBACK=2, FILL=3, ERROR=4)
//   SramSrcCpu   SRAM write data taken from the CPU
//   SramSrcMem   SRAM write data taken from the SDRAM controller
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StHit       = 3'd1,
    StWriteback = 3'd2,
    StFill      = 3'd3,
    StError     = 3'd4
  } state_e;

  localparam logic SramSrcCpu = 1'b0;
  localparam logic SramSrcMem = 1'b1;

endpackage

// File: rtl/xfer_counter.sv
// xfer_counter: word index and stall counter for one line transfer.
//   clk, rst        clock, asynchronous active-high reset
//   i_clear         force both counters to zero
//   i_ack, i_strb   SDRAM handshake; an ack only counts while strobe is high
//   o_word_offset   word index of the current transfer
//   o_last_word     word_offset is at the final word of the line
//   o_timeout       this stalled cycle brings wait_cnt up to TIMEOUT
module xfer_counter #(
  parameter int unsigned WORDS_PER_LINE = 16,
  parameter int unsigned OFF_W          = $clog2(WORDS_PER_LINE),
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_ack,
  input  logic             i_strb,
  output logic [OFF_W-1:0] o_word_offset,
  output logic             o_last_word,
  output logic             o_timeout
);

  localparam int unsigned WaitW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OFF_W-1:0] LastOff  = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [WaitW-1:0] WaitMax  = WaitW'(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  logic [OFF_W-1:0] r_offset;
  logic [WaitW-1:0] r_wait;
  logic             w_take;

  assign w_take = i_strb & i_ack;

  // Offset stops at the last word; only i_clear brings it back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset <= '0;
    end else if (i_clear) begin
      r_offset <= '0;
    end else if (w_take && (r_offset != LastOff)) begin
      r_offset <= r_offset + 1'b1;
    end
  end

  // Counts stalled strobe cycles, saturating at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else if (i_clear || w_take) begin
      r_wait <= '0;
    end else if (i_strb && (r_wait != WaitMax)) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign o_word_offset = r_offset;
  assign o_last_word   = (r_offset == LastOff);
  assign o_timeout     = (TIMEOUT != 0) && i_strb && !i_ack && (r_wait == WaitLast);

endmodule

// File: rtl/cache_line_fsm.sv
// cache_line_fsm: cache-line controller between CPU, tag/SRAM array and SDRAM.
//   clk, rst                          clock, asynchronous active-high reset
//   cpu_req, cpu_wr                   CPU request and direction
//   hit, line_valid, line_dirty       tag-store status of the indexed line
//   mem_ack                           SDRAM moved one word this cycle
//   rdy                               request complete (pulse)
//   wen_sram, sram_src_sel            SRAM write enable and data source
//   cpu_out_sel                       return SRAM data to the CPU
//   mem_strb, mem_wr                  SDRAM request and direction (1 = write-back)
//   word_offset                       word index of the current transfer
//   set_dirty, clr_dirty, set_valid, tag_wr  status-update pulses
//   busy, err                         controller not idle; SDRAM timeout pulse
module cache_line_fsm
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 16,
  parameter int unsigned OFF_W          = $clog2(WORDS_PER_LINE),
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_wr,
  input  logic             hit,
  input  logic             line_valid,
  input  logic             line_dirty,
  input  logic             mem_ack,
  output logic             rdy,
  output logic             wen_sram,
  output logic             sram_src_sel,
  output logic             cpu_out_sel,
  output logic             mem_strb,
  output logic             mem_wr,
  output logic [OFF_W-1:0] word_offset,
  output logic             set_dirty,
  output logic             clr_dirty,
  output logic             set_valid,
  output logic             tag_wr,
  output logic             busy,
  output logic             err
);

  state_e r_state, w_state_next;
  logic   r_wr;
  logic   w_strb, w_clear, w_last, w_timeout;

  // Kept out of the decode block so the counter's timeout does not look like a loop.
  assign w_strb   = (r_state == StWriteback) || (r_state == StFill);
  assign mem_strb = w_strb;
  assign busy     = (r_state != StIdle);

  xfer_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .OFF_W         (OFF_W),
    .TIMEOUT       (TIMEOUT)
  ) u_xfer_counter (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_ack        (mem_ack),
    .i_strb       (w_strb),
    .o_word_offset(word_offset),
    .o_last_word  (w_last),
    .o_timeout    (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == StIdle) && cpu_req) begin
        r_wr <= cpu_wr;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    rdy          = 1'b0;
    wen_sram     = 1'b0;
    sram_src_sel = SramSrcCpu;
    cpu_out_sel  = 1'b0;
    mem_wr       = 1'b0;
    set_dirty    = 1'b0;
    clr_dirty    = 1'b0;
    set_valid    = 1'b0;
    tag_wr       = 1'b0;
    err          = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_clear = 1'b1;
        if (cpu_req) begin
          if (hit) begin
            w_state_next = StHit;
          end else if (line_valid && line_dirty) begin
            w_state_next = StWriteback;
          end else begin
            w_state_next = StFill;
          end
        end
      end
      StHit: begin
        rdy          = 1'b1;
        cpu_out_sel  = 1'b1;
        wen_sram     = r_wr;
        set_dirty    = r_wr;
        w_clear      = 1'b1;
        w_state_next = StIdle;
      end
      StWriteback: begin
        mem_wr = 1'b1;
        if (mem_ack && w_last) begin
          clr_dirty    = 1'b1;
          w_clear      = 1'b1;
          w_state_next = StFill;
        end else if (w_timeout) begin
          w_clear      = 1'b1;
          w_state_next = StError;
        end
      end
      StFill: begin
        sram_src_sel = SramSrcMem;
        wen_sram     = mem_ack;
        if (mem_ack && w_last) begin
          set_valid    = 1'b1;
          tag_wr       = 1'b1;
          w_clear      = 1'b1;
          w_state_next = StHit;  // replay the CPU op against the new line
        end else if (w_timeout) begin
          w_clear      = 1'b1;
          w_state_next = StError;
        end
      end
      StError: begin
        err          = 1'b1;
        rdy          = 1'b1;
        w_clear      = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_line_fsm.sv
// Scoreboard bench: stimulus pushes timestamped expected observations; the monitor
// pops one whenever the DUT shows activity or the entry's cycle arrives.
module tb_cache_line_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 1'b0, cpu_wr = 1'b0, hit = 1'b0;
  logic line_valid = 1'b0, line_dirty = 1'b0, mem_ack = 1'b0;

  logic a_rdy, a_wen, a_src, a_cpu_out, a_strb, a_mem_wr, a_set_dirty, a_clr_dirty;
  logic a_set_valid, a_tag_wr, a_busy, a_err;
  logic [3:0] a_off;
  logic b_rdy, b_wen, b_src, b_cpu_out, b_strb, b_mem_wr, b_set_dirty, b_clr_dirty;
  logic b_set_valid, b_tag_wr, b_busy, b_err;
  logic [1:0] b_off;

  cache_line_fsm #(.WORDS_PER_LINE(16), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .hit(hit),
    .line_valid(line_valid), .line_dirty(line_dirty), .mem_ack(mem_ack),
    .rdy(a_rdy), .wen_sram(a_wen), .sram_src_sel(a_src), .cpu_out_sel(a_cpu_out),
    .mem_strb(a_strb), .mem_wr(a_mem_wr), .word_offset(a_off), .set_dirty(a_set_dirty),
    .clr_dirty(a_clr_dirty), .set_valid(a_set_valid), .tag_wr(a_tag_wr), .busy(a_busy),
    .err(a_err)
  );

  cache_line_fsm #(.WORDS_PER_LINE(4)) u_dut4 (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .hit(hit),
    .line_valid(line_valid), .line_dirty(line_dirty), .mem_ack(mem_ack),
    .rdy(b_rdy), .wen_sram(b_wen), .sram_src_sel(b_src), .cpu_out_sel(b_cpu_out),
    .mem_strb(b_strb), .mem_wr(b_mem_wr), .word_offset(b_off), .set_dirty(b_set_dirty),
    .clr_dirty(b_clr_dirty), .set_valid(b_set_valid), .tag_wr(b_tag_wr), .busy(b_busy),
    .err(b_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rdy, wen, src, cpu_out, strb, mem_wr, set_dirty, clr_dirty, set_valid, tag_wr;
    logic busy, err;
    logic [7:0] off;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   base;
  logic sel = 1'b0;  // 0: observe u_dut, 1: observe u_dut4

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t sample();
    obs_t o;
    if (!sel) begin
      o = {a_rdy, a_wen, a_src, a_cpu_out, a_strb, a_mem_wr, a_set_dirty, a_clr_dirty,
           a_set_valid, a_tag_wr, a_busy, a_err, 8'(a_off)};
    end else begin
      o = {b_rdy, b_wen, b_src, b_cpu_out, b_strb, b_mem_wr, b_set_dirty, b_clr_dirty,
           b_set_valid, b_tag_wr, b_busy, b_err, 8'(b_off)};
    end
    return o;
  endfunction

  // Monitor
  always @(negedge clk) begin
    obs_t o;
    exp_t e;
    logic act;
    o   = sample();
    act = o.rdy | o.wen | o.set_dirty | o.clr_dirty | o.set_valid | o.tag_wr | o.err |
          (o.strb & mem_ack);
    if (q.size() > 0 && (act || q[0].cyc <= cyc)) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || e.o != o) begin
        errors++;
        $display("FAIL event: at cycle %0d got %h, required %h at cycle %0d",
                 cyc, o, e.o, e.cyc);
      end
    end else if (act) begin
      checks++;
      errors++;
      $display("FAIL unexpected activity: at cycle %0d got %h, required no activity", cyc, o);
    end
  end

  function automatic obs_t o_idle();
    obs_t o = '0;
    return o;
  endfunction

  function automatic obs_t o_hit(logic wr);
    obs_t o = '0;
    o.rdy = 1'b1; o.cpu_out = 1'b1; o.wen = wr; o.set_dirty = wr; o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_fill(int off, logic last, logic ack);
    obs_t o = '0;
    o.strb = 1'b1; o.src = 1'b1; o.wen = ack; o.busy = 1'b1; o.off = 8'(off);
    o.set_valid = last; o.tag_wr = last;
    return o;
  endfunction

  function automatic obs_t o_wb(int off, logic last);
    obs_t o = '0;
    o.strb = 1'b1; o.mem_wr = 1'b1; o.busy = 1'b1; o.off = 8'(off); o.clr_dirty = last;
    return o;
  endfunction

  function automatic obs_t o_err();
    obs_t o = '0;
    o.err = 1'b1; o.rdy = 1'b1; o.busy = 1'b1;
    return o;
  endfunction

  function automatic logic ack_for(int mode, int r);
    case (mode)
      0:       return 1'b1;
      2:       return (r % 3 == 0);
      3:       return (r <= 2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input int c, input obs_t o);
    exp_t e;
    e.cyc = c;
    e.o   = o;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; ack pattern for relative cycle r is set at the start of cycle r.
  task automatic run_req(input logic wr, input logic h, input logic v, input logic d,
                         input int mode, input int len);
    cpu_req = 1'b1; cpu_wr = wr; hit = h; line_valid = v; line_dirty = d; mem_ack = 1'b0;
    for (int r = 1; r <= len; r++) begin
      tick();
      cpu_req = 1'b0;
      mem_ack = ack_for(mode, r);
    end
    tick();
    mem_ack = 1'b0; hit = 1'b0; line_valid = 1'b0; line_dirty = 1'b0; cpu_wr = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    push(cyc, o_idle());  // outputs quiet while reset is held
    rst = 1'b0;
    tick();
    mem_ack = 1'b1;  // stray ack in IDLE must be ignored
    push(cyc, o_idle());
    tick();
    mem_ack = 1'b0;

    // Write hit: rdy/wen/set_dirty in cycle 1, idle in cycle 2
    base = cyc;
    push(base + 1, o_hit(1'b1));
    push(base + 2, o_idle());
    run_req(1'b1, 1'b1, 1'b0, 1'b0, 0, 2);

    // Read hit on a dirty line stays a hit
    base = cyc;
    push(base + 1, o_hit(1'b0));
    run_req(1'b0, 1'b1, 1'b1, 1'b1, 0, 1);

    // Clean read miss, zero-wait: 16 fills, rdy at cycle 17
    base = cyc;
    for (int k = 0; k < 16; k++) push(base + 1 + k, o_fill(k, k == 15, 1'b1));
    push(base + 17, o_hit(1'b0));
    push(base + 18, o_idle());
    run_req(1'b0, 1'b0, 1'b0, 1'b0, 0, 18);

    // Dirty read miss, ack every 3rd cycle
    base = cyc;
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) push(base + 47, o_wb(15, 1'b0));  // stalled: offset holds
      push(base + 3 * k, o_wb(k - 1, k == 16));
    end
    push(base + 49, o_fill(0, 1'b0, 1'b0));  // first fill cycle: mem_wr now 0
    for (int k = 1; k <= 16; k++) push(base + 48 + 3 * k, o_fill(k - 1, k == 16, 1'b1));
    push(base + 97, o_hit(1'b0));
    push(base + 98, o_idle());
    run_req(1'b0, 1'b0, 1'b1, 1'b1, 2, 98);

    // Timeout: two words land, then 4 stalled cycles -> ERROR
    base = cyc;
    push(base + 1, o_fill(0, 1'b0, 1'b1));
    push(base + 2, o_fill(1, 1'b0, 1'b1));
    push(base + 6, o_fill(2, 1'b0, 1'b0));
    push(base + 7, o_err());
    push(base + 8, o_idle());
    run_req(1'b0, 1'b0, 1'b0, 1'b0, 3, 8);

    // Reset asserted mid-cycle during FILL word 7
    base = cyc;
    for (int k = 0; k < 7; k++) push(base + 1 + k, o_fill(k, 1'b0, 1'b1));
    push(base + 8, o_idle());
    push(base + 9, o_idle());
    cpu_req = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      tick();
      cpu_req = 1'b0;
      mem_ack = 1'b1;
      if (r == 8) begin
        #2;
        rst = 1'b1;
      end
    end
    tick();
    rst = 1'b0;
    mem_ack = 1'b0;

    // Clean write miss after the abort starts at offset 0 and replays as a write hit
    base = cyc;
    for (int k = 0; k < 16; k++) push(base + 1 + k, o_fill(k, k == 15, 1'b1));
    push(base + 17, o_hit(1'b1));
    push(base + 18, o_idle());
    run_req(1'b1, 1'b0, 1'b0, 1'b0, 0, 18);

    // WORDS_PER_LINE=4: dirty miss, zero-wait, done by cycle 10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sel = 1'b1;
    tick();
    base = cyc;
    for (int k = 0; k < 4; k++) push(base + 1 + k, o_wb(k, k == 3));
    for (int k = 0; k < 4; k++) push(base + 5 + k, o_fill(k, k == 3, 1'b1));
    push(base + 9, o_hit(1'b0));
    push(base + 10, o_idle());
    run_req(1'b0, 1'b0, 1'b1, 1'b1, 0, 10);

    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected events never observed, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
